// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;

    localparam int DEFAULT_MAX_BURST = 8;
    localparam int MAX_NUM_REQ       = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // First set bit of valid_vec strictly after last, wrapping modulo num_req; last if none.
    function automatic logic [3:0] rr_next(
        input logic [3:0]             last,
        input logic [MAX_NUM_REQ-1:0] valid_vec,
        input int                     num_req
    );
        logic [3:0] nxt;
        logic       hit;
        int         idx;
        nxt = last;
        hit = 1'b0;
        for (int k = 1; k <= MAX_NUM_REQ; k++) begin
            idx = (int'(last) + k) % num_req;
            if (!hit && (k <= num_req) && valid_vec[idx[3:0]]) begin
                nxt = idx[3:0];
                hit = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin search over requester valids
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_LEN  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_LEN-1:0]  last_id,
    output logic               found,
    output logic [ID_LEN-1:0]  next_id
);

    logic [MAX_NUM_REQ-1:0] w_valid_ext;
    logic [3:0]             w_last_ext;

    assign w_valid_ext = MAX_NUM_REQ'(valid);
    assign w_last_ext  = 4'(last_id);
    assign found       = |valid;
    assign next_id     = ID_LEN'(rr_next(w_last_ext, w_valid_ext, NUM_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one async_fifo write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_LEN  = 16,
    parameter int ID_LEN    = $clog2(NUM_REQ),
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ID_LEN+DATA_LEN-1:0]   fifo_data_in,
    output logic                         fifo_wrt_en,
    input  logic                         fifo_wrt_full,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          r_state;
    logic [ID_LEN-1:0]   r_grant_id;
    logic [ID_LEN-1:0]   r_last_id;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic                w_in_burst;
    logic [NUM_REQ-1:0]  w_gnt_onehot;
    logic                w_gnt_valid;
    logic                w_gnt_last;
    logic [DATA_LEN-1:0] w_gnt_data;
    logic                w_xfer;
    logic                w_found;
    logic [ID_LEN-1:0]   w_next_id;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_LEN  (ID_LEN)
    ) u_picker (
        .valid   (req_valid),
        .last_id (r_last_id),
        .found   (w_found),
        .next_id (w_next_id)
    );

    assign w_in_burst   = (r_state == ARB_BURST);
    assign w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_gnt_valid  = |(req_valid & w_gnt_onehot);
    assign w_gnt_last   = |(req_last & w_gnt_onehot);

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_LEN'(i)) begin
                w_gnt_data = req_data[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Outputs decode straight from state so an async reset kills a write in the same cycle.
    assign req_ready    = (w_in_burst && !fifo_wrt_full) ? w_gnt_onehot : '0;
    assign w_xfer       = w_in_burst && !fifo_wrt_full && w_gnt_valid;
    assign fifo_wrt_en  = w_xfer;
    assign fifo_data_in = {r_grant_id, w_gnt_data};
    assign grant        = w_in_burst ? w_gnt_onehot : '0;
    assign busy         = w_in_burst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= '0;
            r_last_id  <= ID_LEN'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_next_id;
                        r_last_id  <= w_next_id;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    // A full FIFO only stalls; a dropped valid abandons the grant.
                    if (!w_gnt_valid) begin
                        r_state <= ARB_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_gnt_last || ((r_beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST))) begin
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_LEN  = 16;
    localparam int ID_LEN    = 2;
    localparam int MAX_BURST = 8;

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [ID_LEN+DATA_LEN-1:0]  fifo_data_in;
    logic                        fifo_wrt_en;
    logic                        fifo_wrt_full;
    logic [NUM_REQ-1:0]          grant;
    logic                        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_LEN  (DATA_LEN),
        .ID_LEN    (ID_LEN),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_data_in  (fifo_data_in),
        .fifo_wrt_en   (fifo_wrt_en),
        .fifo_wrt_full (fifo_wrt_full),
        .grant         (grant),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        req_valid     = 4'b1111;
        req_last      = 4'b0000;
        req_data      = '0;
        fifo_wrt_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (fifo_wrt_en !== 1'b0) begin n_fail++; $display("FAIL reset_wrt_en: got %b expected 0", fifo_wrt_en); end
        n_cmp++; if (dut.r_last_id !== 2'd3) begin n_fail++; $display("FAIL reset_last_id: got %0d expected 3", dut.r_last_id); end
        n_cmp++; if (dut.r_beat_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", dut.r_beat_cnt); end
        n_cmp++; if (dut.r_grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", dut.r_grant_id); end
        req_valid = 4'b0000;
        reset_n   = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int sent = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            req_valid        = (sent < 3) ? 4'b0001 : 4'b0000;
            req_last         = (sent == 2) ? 4'b0001 : 4'b0000;
            req_data[15:0]   = 16'h0A00 + 16'(sent);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_arb_grant: got %b expected 0000", grant); end
                n_cmp++; if (fifo_wrt_en !== 1'b0) begin n_fail++; $display("FAIL single_arb_wrt_en: got %b expected 0", fifo_wrt_en); end
            end
            if (cyc >= 1 && cyc <= 3) begin
                n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant c%0d: got %b expected 0001", cyc, grant); end
                n_cmp++; if (fifo_wrt_en !== 1'b1) begin n_fail++; $display("FAIL single_wrt_en c%0d: got %b expected 1", cyc, fifo_wrt_en); end
                n_cmp++; if (fifo_data_in !== {2'd0, 16'h0A00 + 16'(cyc - 1)}) begin n_fail++; $display("FAIL single_data c%0d: got %h expected %h", cyc, fifo_data_in, {2'd0, 16'h0A00 + 16'(cyc - 1)}); end
            end
            if (cyc == 4) begin
                n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL single_idle_after: got busy=%b grant=%b expected 0/0000", busy, grant); end
            end
            if (fifo_wrt_en === 1'b1) sent++;
            tick();
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
    endtask

    task automatic test_burst_cap();
        int sent = 0;
        int cur  = 0;
        int runs[$];
        for (int cyc = 0; cyc < 30; cyc++) begin
            req_valid       = (sent < 20) ? 4'b0100 : 4'b0000;
            req_last        = 4'b0000;
            req_data[47:32] = 16'h2000 + 16'(sent);
            #1;
            if (fifo_wrt_en === 1'b1) begin
                n_cmp++; if (fifo_data_in !== {2'd2, 16'h2000 + 16'(sent)}) begin n_fail++; $display("FAIL cap_data w%0d: got %h expected %h", sent, fifo_data_in, {2'd2, 16'h2000 + 16'(sent)}); end
                cur++;
                sent++;
            end else begin
                if (cur > 0) runs.push_back(cur);
                cur = 0;
                if (sent > 0 && sent < 20) begin
                    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cap_gap_idle c%0d: got busy=%b expected 0", cyc, busy); end
                end
            end
            tick();
        end
        if (cur > 0) runs.push_back(cur);
        n_cmp++; if (sent !== 20) begin n_fail++; $display("FAIL cap_total: got %0d expected 20", sent); end
        n_cmp++; if (runs.size() !== 3) begin n_fail++; $display("FAIL cap_nruns: got %0d expected 3", runs.size()); end
        if (runs.size() == 3) begin
            n_cmp++; if (runs[0] !== 8) begin n_fail++; $display("FAIL cap_run0: got %0d expected 8", runs[0]); end
            n_cmp++; if (runs[1] !== 8) begin n_fail++; $display("FAIL cap_run1: got %0d expected 8", runs[1]); end
            n_cmp++; if (runs[2] !== 4) begin n_fail++; $display("FAIL cap_run2: got %0d expected 4", runs[2]); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [15:0] pay [4];
        int writes = 0;
        pay[0] = 16'hC000; pay[1] = 16'hC111; pay[2] = 16'hC222; pay[3] = 16'hC333;
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        req_data  = {pay[3], pay[2], pay[1], pay[0]};
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int cyc = 0; cyc < 40 && writes < 8; cyc++) begin
            #1;
            if (fifo_wrt_en === 1'b1) begin
                n_cmp++; if (fifo_data_in !== {2'(writes % 4), pay[writes % 4]}) begin n_fail++; $display("FAIL fair_data w%0d: got %h expected %h", writes, fifo_data_in, {2'(writes % 4), pay[writes % 4]}); end
                n_cmp++; if (grant !== 4'(1 << (writes % 4))) begin n_fail++; $display("FAIL fair_grant w%0d: got %b expected %b", writes, grant, 4'(1 << (writes % 4))); end
                writes++;
            end
            tick();
        end
        n_cmp++; if (writes !== 8) begin n_fail++; $display("FAIL fair_count: got %0d expected 8", writes); end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tick();
    endtask

    task automatic test_full_stall();
        int sent = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            req_valid       = (sent < 4) ? 4'b0010 : 4'b0000;
            req_last        = (sent == 3) ? 4'b0010 : 4'b0000;
            req_data[31:16] = 16'h1100 + 16'(sent);
            fifo_wrt_full   = (cyc >= 3 && cyc <= 7);
            #1;
            if (cyc >= 3 && cyc <= 7) begin
                n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready c%0d: got %b expected 0000", cyc, req_ready); end
                n_cmp++; if (fifo_wrt_en !== 1'b0) begin n_fail++; $display("FAIL stall_wrt_en c%0d: got %b expected 0", cyc, fifo_wrt_en); end
                n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL stall_grant c%0d: got %b expected 0010", cyc, grant); end
                n_cmp++; if (dut.r_beat_cnt !== 4'd2) begin n_fail++; $display("FAIL stall_beat c%0d: got %0d expected 2", cyc, dut.r_beat_cnt); end
            end
            if (cyc == 8 || cyc == 9) begin
                n_cmp++; if (fifo_wrt_en !== 1'b1) begin n_fail++; $display("FAIL stall_resume c%0d: got %b expected 1", cyc, fifo_wrt_en); end
            end
            if (cyc == 10) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_idle: got %b expected 0", busy); end
            end
            if (fifo_wrt_en === 1'b1) begin
                n_cmp++; if (fifo_data_in !== {2'd1, 16'h1100 + 16'(sent)}) begin n_fail++; $display("FAIL stall_data w%0d: got %h expected %h", sent, fifo_data_in, {2'd1, 16'h1100 + 16'(sent)}); end
                sent++;
            end
            tick();
        end
        n_cmp++; if (sent !== 4) begin n_fail++; $display("FAIL stall_total: got %0d expected 4", sent); end
        fifo_wrt_full = 1'b0;
        req_valid     = 4'b0000;
        req_last      = 4'b0000;
    endtask

    task automatic test_abandon();
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL abandon_arb: got %b expected 0000", grant); end
        tick();
        req_valid      = 4'b0001;
        req_last       = 4'b0001;
        req_data[15:0] = 16'h0AB0;
        #1;
        n_cmp++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL abandon_grant3: got %b expected 1000", grant); end
        n_cmp++; if (fifo_wrt_en !== 1'b0) begin n_fail++; $display("FAIL abandon_no_write: got %b expected 0", fifo_wrt_en); end
        tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abandon_idle: got %b expected 0", busy); end
        n_cmp++; if (dut.r_last_id !== 2'd3) begin n_fail++; $display("FAIL abandon_last_id: got %0d expected 3", dut.r_last_id); end
        tick();
        #1;
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abandon_next: got %b expected 0001", grant); end
        n_cmp++; if (fifo_wrt_en !== 1'b1 || fifo_data_in !== {2'd0, 16'h0AB0}) begin n_fail++; $display("FAIL abandon_next_write: got en=%b data=%h expected 1/%h", fifo_wrt_en, fifo_data_in, {2'd0, 16'h0AB0}); end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        for (int cyc = 0; cyc < 4; cyc++) begin
            req_data[31:16] = 16'h1500 + 16'(cyc);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_arb: got %b expected 0000", grant); end
            end else begin
                n_cmp++; if (fifo_wrt_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_write c%0d: got %b expected 1", cyc, fifo_wrt_en); end
            end
            if (cyc < 3) tick();
        end
        req_valid = 4'b0011;
        reset_n   = 1'b0;
        #1;
        n_cmp++; if (fifo_wrt_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wrt_en: got %b expected 0", fifo_wrt_en); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0000", grant); end
        tick();
        reset_n        = 1'b1;
        req_data[15:0] = 16'h0E00;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_release_idle: got %b expected 0000", grant); end
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first_winner: got %b expected 0001", grant); end
        n_cmp++; if (fifo_data_in !== {2'd0, 16'h0E00}) begin n_fail++; $display("FAIL rst_mid_first_data: got %h expected %h", fifo_data_in, {2'd0, 16'h0E00}); end
        req_valid = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_cap();
        test_fairness();
        test_full_stall();
        test_abandon();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
